// File: rtl/wb_pkg.sv
// Shared constants for the MEM/WB writeback stage: result-source encodings
// and load funct3 codes.
package wb_pkg;

  localparam int RES_ALU = 0;
  localparam int RES_MEM = 1;
  localparam int RES_PC4 = 2;
  localparam int RES_IMM = 3;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;

endpackage

// File: rtl/writeback_stage_load_extend.sv
// Combinational sub-word load extraction (LB/LBU/LH/LHU); LW and reserved
// funct3 codes pass the word through unchanged.
module load_extend
  import wb_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] word,
  input  logic [2:0]       funct3,
  input  logic [1:0]       offset,
  output logic [WIDTH-1:0] extended
);

  logic [7:0]  loadByte;
  logic [15:0] loadHalf;

  assign loadByte = word[{offset, 3'b000} +: 8];
  assign loadHalf = word[{offset[1], 4'b0000} +: 16];

  always_comb begin
    extended = word;
    case (funct3)
      F3_LB:   extended = {{(WIDTH-8){loadByte[7]}}, loadByte};
      F3_LBU:  extended = {{(WIDTH-8){1'b0}}, loadByte};
      F3_LH:   extended = {{(WIDTH-16){loadHalf[15]}}, loadHalf};
      F3_LHU:  extended = {{(WIDTH-16){1'b0}}, loadHalf};
      default: extended = word;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// MEM/WB pipeline register: result-source select, register-file write port,
// retire counter and sticky illegal-select flag. Define WB_LOAD_EXT_EN to
// route load data through sub-word extraction.
module writeback_stage
  import wb_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int NUM_SRC = 4,
  parameter int SEL_W   = $clog2(NUM_SRC),
  parameter int REG_AW  = 5,
  parameter int CNT_W   = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     inValid,
  output logic                     inReady,
  input  logic [NUM_SRC*WIDTH-1:0] srcData,
  input  logic [SEL_W-1:0]         resultSrc,
  input  logic [REG_AW-1:0]        rdIn,
  input  logic                     regWriteIn,
  input  logic [2:0]               funct3In,
  input  logic [1:0]               byteOffIn,
  input  logic                     stall,
  input  logic                     flush,
  output logic                     wbValid,
  output logic                     regWrite,
  output logic [REG_AW-1:0]        rd,
  output logic [WIDTH-1:0]         result,
  output logic [CNT_W-1:0]         retireCnt,
  output logic                     selErr
);

  logic [WIDTH-1:0] selected;
  logic [WIDTH-1:0] memWord;
  logic [WIDTH-1:0] memFinal;
  logic             selIllegal;
  logic             accept;

  assign inReady    = !stall;
  assign accept     = inValid && !stall && !flush;
  assign selIllegal = int'(resultSrc) >= NUM_SRC;
  assign memWord    = srcData[RES_MEM*WIDTH +: WIDTH];

`ifdef WB_LOAD_EXT_EN
  load_extend #(.WIDTH(WIDTH)) uLoadExtend (
    .word     (memWord),
    .funct3   (funct3In),
    .offset   (byteOffIn),
    .extended (memFinal)
  );
`else
  assign memFinal = memWord;
`endif

  // Illegal selects fall through every arm and leave the result at zero
  always_comb begin
    selected = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (int'(resultSrc) == k) begin
        selected = (k == RES_MEM) ? memFinal : srcData[k*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wbValid   <= 1'b0;
      regWrite  <= 1'b0;
      rd        <= '0;
      result    <= '0;
      retireCnt <= '0;
      selErr    <= 1'b0;
    end else begin
      if (wbValid && !stall && !flush) begin
        retireCnt <= retireCnt + CNT_W'(1);
      end
      // Flush beats stall; stall freezes everything including wbValid
      if (flush) begin
        wbValid  <= 1'b0;
        regWrite <= 1'b0;
      end else if (!stall) begin
        wbValid  <= inValid;
        regWrite <= inValid && regWriteIn && (rdIn != '0);
      end
      if (accept) begin
        rd     <= rdIn;
        result <= selected;
        if (selIllegal) begin
          selErr <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_writeback_stage.sv
// Directed self-checking bench for writeback_stage: a default instance and a
// NUM_SRC=3 / CNT_W=4 instance for illegal-select and counter wrap.
module tb_writeback_stage;

  logic        clk;
  logic        reset;
  logic        inValid;
  logic [127:0] srcData;
  logic [95:0]  srcData1;
  logic [1:0]  resultSrc;
  logic [1:0]  resultSrc1;
  logic [4:0]  rdIn;
  logic        regWriteIn;
  logic [2:0]  funct3In;
  logic [1:0]  byteOffIn;
  logic        stall;
  logic        flush;

  logic        inReady, wbValid, regWrite, selErr;
  logic [4:0]  rd;
  logic [31:0] result;
  logic [31:0] retireCnt;

  logic        inReady1, wbValid1, regWrite1, selErr1;
  logic [4:0]  rd1;
  logic [31:0] result1;
  logic [3:0]  retireCnt1;

  int total = 0;
  int bad   = 0;

  writeback_stage dut (
    .clk(clk), .reset(reset), .inValid(inValid), .inReady(inReady),
    .srcData(srcData), .resultSrc(resultSrc), .rdIn(rdIn),
    .regWriteIn(regWriteIn), .funct3In(funct3In), .byteOffIn(byteOffIn),
    .stall(stall), .flush(flush), .wbValid(wbValid), .regWrite(regWrite),
    .rd(rd), .result(result), .retireCnt(retireCnt), .selErr(selErr)
  );

  writeback_stage #(.NUM_SRC(3), .CNT_W(4)) dutSmall (
    .clk(clk), .reset(reset), .inValid(inValid), .inReady(inReady1),
    .srcData(srcData1), .resultSrc(resultSrc1), .rdIn(rdIn),
    .regWriteIn(regWriteIn), .funct3In(funct3In), .byteOffIn(byteOffIn),
    .stall(stall), .flush(flush), .wbValid(wbValid1), .regWrite(regWrite1),
    .rd(rd1), .result(result1), .retireCnt(retireCnt1), .selErr(selErr1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [1:0] sel,
                               input logic [4:0] rdv, input logic rw,
                               input logic [2:0] f3, input logic [1:0] off);
    inValid    = v;
    resultSrc  = sel;
    rdIn       = rdv;
    regWriteIn = rw;
    funct3In   = f3;
    byteOffIn  = off;
  endtask

  logic [31:0] expLb, expLbu, expLh, expLhu;

  initial begin
`ifdef WB_LOAD_EXT_EN
    expLb = 32'hFFFFFFAB; expLbu = 32'h000000F0;
    expLh = 32'hFFFF8070; expLhu = 32'h00008070;
`else
    expLb = 32'h8070F0AB; expLbu = 32'h8070F0AB;
    expLh = 32'h8070F0AB; expLhu = 32'h8070F0AB;
`endif
    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    srcData  = {32'd4, 32'd3, 32'd2, 32'd1};
    srcData1 = {32'h33, 32'h22, 32'h11};
    resultSrc1 = 2'd0;
    applyStimulus(1'b0, 2'd0, 5'd0, 1'b0, 3'd2, 2'd0);
    tick(); tick();
    reset = 1'b0;
    checkOutput("rst_wbValid", 64'(wbValid), 64'd0);
    checkOutput("rst_regWrite", 64'(regWrite), 64'd0);
    checkOutput("rst_rd", 64'(rd), 64'd0);
    checkOutput("rst_result", 64'(result), 64'd0);
    checkOutput("rst_retire", 64'(retireCnt), 64'd0);
    checkOutput("rst_selErr", 64'(selErr), 64'd0);
    checkOutput("inReady_idle", 64'(inReady), 64'd1);

    // Four back-to-back accepts, one per source (LW keeps load data whole)
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 2'(k), 5'd1, 1'b1, 3'd2, 2'd0);
      tick();
      checkOutput($sformatf("src%0d_result", k), 64'(result), 64'(k + 1));
      checkOutput($sformatf("src%0d_retire", k), 64'(retireCnt), 64'(k));
    end
    applyStimulus(1'b0, 2'd0, 5'd0, 1'b0, 3'd2, 2'd0);
    tick();
    checkOutput("idle_wbValid", 64'(wbValid), 64'd0);
    checkOutput("idle_retire", 64'(retireCnt), 64'd4);

    applyStimulus(1'b1, 2'd0, 5'd0, 1'b1, 3'd2, 2'd0);
    tick();
    checkOutput("x0_wbValid", 64'(wbValid), 64'd1);
    checkOutput("x0_regWrite", 64'(regWrite), 64'd0);
    applyStimulus(1'b1, 2'd0, 5'd5, 1'b1, 3'd2, 2'd0);
    tick();
    checkOutput("rd5_regWrite", 64'(regWrite), 64'd1);
    checkOutput("rd5_rd", 64'(rd), 64'd5);
    checkOutput("rd5_retire", 64'(retireCnt), 64'd5);

    // Stall for three cycles with new input offered; flush joins on the third
    applyStimulus(1'b1, 2'd3, 5'd7, 1'b1, 3'd2, 2'd0);
    stall = 1'b1;
    #1;
    checkOutput("stall_inReady", 64'(inReady), 64'd0);
    for (int c = 0; c < 2; c++) begin
      tick();
      checkOutput($sformatf("stall%0d_rd", c), 64'(rd), 64'd5);
      checkOutput($sformatf("stall%0d_result", c), 64'(result), 64'd1);
      checkOutput($sformatf("stall%0d_wbValid", c), 64'(wbValid), 64'd1);
      checkOutput($sformatf("stall%0d_retire", c), 64'(retireCnt), 64'd5);
    end
    flush = 1'b1;
    tick();
    checkOutput("flush_wbValid", 64'(wbValid), 64'd0);
    checkOutput("flush_regWrite", 64'(regWrite), 64'd0);
    checkOutput("flush_retire", 64'(retireCnt), 64'd5);
    stall = 1'b0; flush = 1'b0;

    srcData = {32'd4, 32'd3, 32'h8070F0AB, 32'd1};
    applyStimulus(1'b1, 2'd1, 5'd3, 1'b1, 3'd0, 2'd0);
    tick(); checkOutput("lb_off0", 64'(result), 64'(expLb));
    applyStimulus(1'b1, 2'd1, 5'd3, 1'b1, 3'd4, 2'd1);
    tick(); checkOutput("lbu_off1", 64'(result), 64'(expLbu));
    applyStimulus(1'b1, 2'd1, 5'd3, 1'b1, 3'd1, 2'd2);
    tick(); checkOutput("lh_off2", 64'(result), 64'(expLh));
    applyStimulus(1'b1, 2'd1, 5'd3, 1'b1, 3'd5, 2'd3);
    tick(); checkOutput("lhu_off3", 64'(result), 64'(expLhu));
    applyStimulus(1'b1, 2'd1, 5'd3, 1'b1, 3'd2, 2'd1);
    tick(); checkOutput("lw_off1", 64'(result), 64'h8070F0AB);

    // Small instance: illegal select, sticky flag and 4-bit counter wrap
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("small_rst_retire", 64'(retireCnt1), 64'd0);
    resultSrc1 = 2'd3;
    applyStimulus(1'b1, 2'd0, 5'd2, 1'b1, 3'd2, 2'd0);
    tick();
    checkOutput("illegal_result", 64'(result1), 64'd0);
    checkOutput("illegal_selErr", 64'(selErr1), 64'd1);
    checkOutput("illegal_wbValid", 64'(wbValid1), 64'd1);
    checkOutput("legal_big_selErr", 64'(selErr), 64'd0);
    resultSrc1 = 2'd0;
    for (int n = 0; n < 16; n++) tick();
    applyStimulus(1'b0, 2'd0, 5'd0, 1'b0, 3'd2, 2'd0);
    tick();
    checkOutput("wrap_retire", 64'(retireCnt1), 64'd1);
    checkOutput("sticky_selErr", 64'(selErr1), 64'd1);
    checkOutput("legal_result", 64'(result1), 64'h11);
    checkOutput("legal_rd", 64'(rd1), 64'd2);

    // Reset with a live instruction discards it uncounted
    applyStimulus(1'b1, 2'd0, 5'd9, 1'b1, 3'd2, 2'd0);
    tick();
    reset = 1'b1;
    applyStimulus(1'b0, 2'd0, 5'd0, 1'b0, 3'd2, 2'd0);
    tick();
    reset = 1'b0;
    checkOutput("rst2_wbValid", 64'(wbValid1), 64'd0);
    checkOutput("rst2_regWrite", 64'(regWrite1), 64'd0);
    checkOutput("rst2_rd", 64'(rd1), 64'd0);
    checkOutput("rst2_result", 64'(result1), 64'd0);
    checkOutput("rst2_retire", 64'(retireCnt1), 64'd0);
    checkOutput("rst2_selErr", 64'(selErr1), 64'd0);
    tick();
    checkOutput("post_rst_retire", 64'(retireCnt), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/writeback_stage.md
# writeback_stage

Parametrised MEM/WB pipeline stage for the pipelined RISC-V core: the successor to the single-cycle result multiplexer. Registers one instruction per cycle from the memory stage, selects among `NUM_SRC` result sources, optionally extracts and extends sub-word load data, and drives the register-file write port. It also maintains a retired-instruction counter and a sticky illegal-select flag.

## Interface
- `WIDTH`, 32: datapath width.
- `NUM_SRC`, 4: result sources; index 0 ALU, 1 load data, 2 PC+4, 3 immediate (LUI).
- `SEL_W`, `$clog2(NUM_SRC)`: width of the select field.
- `REG_AW`, 5: register address width.
- `CNT_W`, 32: retired-instruction counter width.

- `clk` in 1: clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `inValid` in 1: upstream instruction valid.
- `inReady` out 1: stage accepts this cycle.
- `srcData` in `NUM_SRC*WIDTH`: packed sources; source k at `[k*WIDTH +: WIDTH]`.
- `resultSrc` in `SEL_W`: source select.
- `rdIn` in `REG_AW`: destination register.
- `regWriteIn` in 1: instruction writes the register file.
- `funct3In` in 3: load type.
- `byteOffIn` in 2: `aluResult[1:0]` of the load address.
- `stall` in 1: hold stage contents (hazard unit).
- `flush` in 1: kill stage contents.
- `wbValid` out 1: stage holds a live instruction.
- `regWrite` out 1: register-file write enable.
- `rd` out `REG_AW`: write address.
- `result` out `WIDTH`: write data.
- `retireCnt` out `CNT_W`: retired instructions.
- `selErr` out 1: sticky illegal-select flag.

## Operation
- `inReady = !stall`. Accept occurs when `inValid && inReady`.
- On accept, register: `wbValid<=1`, `rd`, `regWriteIn`, and the selected, extended `result`.
- `inValid=0` with `!stall`: `wbValid<=0`; data registers may hold stale values.
- `stall=1`: all stage registers hold; `inValid` is ignored.
- `flush=1`: `wbValid<=0` next cycle, overriding both accept and stall.
- `regWrite = wbValid && regWriteQ && (rd != 0)`; x0 is never written.
- `resultSrc >= NUM_SRC` on accept: registered `result=0`, and `selErr<=1` remains set until reset.
- `retireCnt` increments on every cycle where `wbValid && !stall && !flush`, i.e. when an instruction leaves the stage. The counter wraps modulo 2^CNT_W.
- Reset forces `wbValid=0`, `regWrite=0`, `rd=0`, `result=0`, `retireCnt=0`, `selErr=0`. Reset overrides flush, stall and accept. A reset asserted while the stage holds a live instruction discards it without counting it.

## Timing
- Latency is 1 cycle: an input accepted at edge N appears on `result`, `rd`, `regWrite` after edge N and stays until the next accept, flush or stall release.
- `inReady` is combinational from `stall` only, with no path from `inValid`.
- All outputs except `inReady` are registered.
- Flush and stall in the same cycle: flush wins, and the retire count does not increment.
- Back-to-back accepts sustain one instruction per cycle.

## Configuration
- `WB_LOAD_EXT_EN` defined: when `resultSrc==1`, source 1 passes through load extension before registering.
  - LB/LBU select byte `byteOffIn`, sign- or zero-extended.
  - LH/LHU select halfword `byteOffIn[1]`, sign- or zero-extended; `byteOffIn[0]` is ignored.
  - LW and reserved codes 3, 6, 7 pass the word unchanged.
- `WB_LOAD_EXT_EN` undefined: source 1 passes unchanged; `funct3In` and `byteOffIn` are ignored but the ports remain.

## Structure
- Package `wb_pkg` holds:
  - result-source encodings `RES_ALU=0`, `RES_MEM=1`, `RES_PC4=2`, `RES_IMM=3`;
  - load funct3 constants `F3_LB=0`, `F3_LH=1`, `F3_LW=2`, `F3_LBU=4`, `F3_LHU=5`.
- Sub-module `load_extend` is purely combinational: inputs word, funct3 and offset; output extended word. It is instantiated only under `WB_LOAD_EXT_EN`.

## Test plan
- Sources ALU=1, MEM=2, PC4=3, IMM=4; `resultSrc` 0..3 on consecutive accepts → `result` 1,2,3,4 one cycle later each; `retireCnt` reaches 4.
- `rdIn=0`, `regWriteIn=1` accepted → `wbValid=1`, `regWrite=0`; `rdIn=5` → `regWrite=1`, `rd=5`.
- Accept with `stall=1` for 3 cycles → outputs frozen and `retireCnt` unchanged. Add `flush` on the third cycle → `wbValid=0` next cycle and no increment.
- With `WB_LOAD_EXT_EN`: MEM=`0x8070F0AB`.
  - LB with offset 0 → `0xFFFFFFAB`.
  - LBU with offset 1 → `0x000000F0`.
  - LH with offset 2 → `0xFFFF8070`.
  - LHU with offset 3 → `0x00008070`.
  - Without the macro, every case returns `0x8070F0AB`.
- `NUM_SRC=3` and `resultSrc=3` → `result=0` and `selErr=1` held across later legal accepts; reset clears all outputs to 0.
- `CNT_W=4`, 17 retirements → `retireCnt=1`.
